johnson_seq_ctrl: RTL and testbench

//  Command-driven sequencer owning an N-bit Johnson counter register (2N legal states).

---
 rtl/johnson_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// Command-driven Johnson counter sequencer.
// Supports CLEAR/LOAD/RUN commands, step runs, abort, phase decode and a sticky error.
module johnson_seq_ctrl #(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int PH_W  = $clog2(2*N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [N-1:0]     cmd_data,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             abort,
    output logic [N-1:0]     jc_q,
    output logic [PH_W-1:0]  phase,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           state_q;
    logic             dir_q;
    logic [CNT_W-1:0] rem_q;
    logic             done_q;
    logic             err_q;

    logic [PH_W:0]    jc_dec;
    logic [PH_W:0]    data_dec;
    logic [N-1:0]     step_d;

    // Returns {legal, phase}; illegal patterns decode to {0, 0}.
    function automatic logic [PH_W:0] decode(input logic [N-1:0] p);
        logic [N-1:0] ones;
        logic [PH_W:0] r;
        ones = '1;
        r    = '0;
        for (int k = 0; k <= N; k++) begin
            if (p == ~(ones >> k))
                r = {1'b1, PH_W'(k)};
        end
        for (int k = 1; k < N; k++) begin
            if (p == (ones >> (N - k)))
                r = {1'b1, PH_W'(2*N - k)};
        end
        return r;
    endfunction

    assign jc_dec   = decode(jc_q);
    assign data_dec = decode(cmd_data);
    assign phase    = jc_dec[PH_W-1:0];

    assign step_d = dir_q ? {jc_q[N-2:0], ~jc_q[N-1]}
                          : {~jc_q[0], jc_q[N-1:1]};

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN);
    assign done      = done_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            jc_q    <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        unique case (cmd_op)
                            2'b00: begin
                                jc_q  <= '0;
                                err_q <= 1'b0;
                            end
                            2'b01: begin
                                if (data_dec[PH_W])
                                    jc_q <= cmd_data;
                                else
                                    err_q <= 1'b1;
                            end
                            2'b10: begin
                                if (cmd_steps == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    state_q <= S_RUN;
                                    rem_q   <= cmd_steps;
                                    dir_q   <= cmd_dir;
                                end
                            end
                            2'b11: err_q <= 1'b1;
                        endcase
                    end
                end
                S_RUN: begin
                    // Abort wins over the step scheduled for this edge.
                    if (abort) begin
                        state_q <= S_IDLE;
                    end else begin
                        jc_q  <= step_d;
                        rem_q <= rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Testbench for johnson_seq_ctrl.
// Runs directed and random commands against a phase-level reference model.
module tb_johnson_seq_ctrl;

    localparam int N     = 8;
    localparam int CNT_W = 16;
    localparam int PH_W  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic [N-1:0]     cmd_data;
    logic [CNT_W-1:0] cmd_steps;
    logic             abort;
    logic [N-1:0]     jc_q;
    logic [PH_W-1:0]  phase;
    logic             busy;
    logic             done;
    logic             err;

    johnson_seq_ctrl #(.N(N), .CNT_W(CNT_W), .PH_W(PH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_data  (cmd_data),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .jc_q      (jc_q),
        .phase     (phase),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int m_phase = 0;
    int m_rem   = 0;
    bit m_busy  = 0;
    bit m_dir   = 0;
    bit m_done  = 0;
    bit m_err   = 0;
    int busy_cnt;
    bit saw_ready;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pattern for a phase: counted as ones filling in from the MSB, then
    // zeros filling in from the MSB over the second half of the cycle.
    function automatic logic [N-1:0] pat_of(input int p);
        logic [N-1:0] r;
        for (int j = 0; j < N; j++)
            r[N-1-j] = (p <= N) ? (j < p) : (j >= p - N);
        return r;
    endfunction

    function automatic int phase_of(input logic [N-1:0] d);
        for (int p = 0; p < 2*N; p++)
            if (pat_of(p) == d) return p;
        return -1;
    endfunction

    task automatic model(input bit r, input bit v, input int op,
                         input bit dir, input logic [N-1:0] data,
                         input int steps, input bit ab);
        if (r) begin
            m_phase = 0; m_busy = 0; m_done = 0; m_err = 0; m_rem = 0;
            return;
        end
        m_done = 0;
        if (!m_busy) begin
            if (v) begin
                case (op)
                    0: begin m_phase = 0; m_err = 0; end
                    1: if (phase_of(data) >= 0) m_phase = phase_of(data);
                       else m_err = 1;
                    2: if (steps == 0) m_done = 1;
                       else begin m_busy = 1; m_rem = steps; m_dir = dir; end
                    default: m_err = 1;
                endcase
            end
        end else if (ab) begin
            m_busy = 0;
        end else begin
            m_phase = (m_phase + (m_dir ? 2*N - 1 : 1)) % (2*N);
            m_rem--;
            if (m_rem == 0) begin m_busy = 0; m_done = 1; end
        end
    endtask

    // One clock: drive after negedge, model at posedge, compare at negedge.
    task automatic cyc(input bit r, input bit v, input int op, input bit dir,
                       input logic [N-1:0] data, input int steps, input bit ab);
        rst = r; cmd_valid = v; cmd_op = op[1:0]; cmd_dir = dir;
        cmd_data = data; cmd_steps = steps[CNT_W-1:0]; abort = ab;
        @(posedge clk);
        model(r, v, op, dir, data, steps, ab);
        @(negedge clk);
        check("jc_q", jc_q, pat_of(m_phase));
        check("phase", phase, m_phase);
        check("busy", busy, m_busy);
        check("ready", cmd_ready, !m_busy);
        check("done", done, m_done);
        check("err", err, m_err);
        if (busy) busy_cnt++;
        if (busy && cmd_ready) saw_ready = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_op = 0; cmd_dir = 0;
        cmd_data = 0; cmd_steps = 0; abort = 0;
        busy_cnt = 0; saw_ready = 0;
        @(negedge clk);
        cyc(1, 0, 0, 0, '0, 0, 0);
        check("rst_jc", jc_q, 0);
        check("rst_busy", busy, 0);

        // forward 3 steps
        busy_cnt = 0;
        cyc(0, 1, 2, 0, '0, 3, 0);
        cyc(0, 0, 0, 0, '0, 0, 0);
        check("t1_s1", jc_q, 8'h80);
        cyc(0, 0, 0, 0, '0, 0, 0);
        check("t1_s2", jc_q, 8'hC0);
        cyc(0, 0, 0, 0, '0, 0, 0);
        check("t1_s3", jc_q, 8'hE0);
        check("t1_ph", phase, 3);
        check("t1_done", done, 1);
        check("t1_busycnt", busy_cnt, 3);
        idle(1);

        // full wrap from FF
        cyc(0, 1, 1, 0, 8'hFF, 0, 0);
        check("t2_ld", phase, 8);
        cyc(0, 1, 2, 0, '0, 16, 0);
        cyc(0, 0, 0, 0, '0, 0, 0);
        check("t2_7f", jc_q, 8'h7F);
        check("t2_ph9", phase, 9);
        idle(7);
        check("t2_00", jc_q, 8'h00);
        idle(8);
        check("t2_ff", jc_q, 8'hFF);
        check("t2_done", done, 1);

        // reverse 2 steps
        cyc(1, 0, 0, 0, '0, 0, 0);
        cyc(0, 1, 2, 1, '0, 2, 0);
        cyc(0, 0, 0, 0, '0, 0, 0);
        check("t3_01", jc_q, 8'h01);
        check("t3_ph15", phase, 15);
        cyc(0, 0, 0, 0, '0, 0, 0);
        check("t3_03", jc_q, 8'h03);
        check("t3_ph14", phase, 14);

        // illegal load, clear
        cyc(0, 1, 1, 0, 8'h5A, 0, 0);
        check("t4_err", err, 1);
        check("t4_hold", jc_q, 8'h03);
        cyc(0, 1, 3, 0, '0, 0, 0);
        cyc(0, 1, 0, 0, '0, 0, 0);
        check("t4_clr", err, 0);

        // abort after 4 steps, then reset mid-run
        cyc(0, 1, 2, 0, '0, 10, 0);
        idle(4);
        cyc(0, 0, 0, 0, '0, 0, 1);
        check("t5_f0", jc_q, 8'hF0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        cyc(0, 1, 2, 0, '0, 10, 0);
        idle(3);
        cyc(1, 0, 0, 0, '0, 0, 0);
        check("t5_rst", jc_q, 8'h00);

        // zero-step run, ready low in RUN
        busy_cnt = 0;
        cyc(0, 1, 2, 0, '0, 0, 0);
        check("t6_done", done, 1);
        check("t6_busy", busy_cnt, 0);
        saw_ready = 0;
        cyc(0, 1, 2, 1, '0, 5, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 8'hFF, 0, 0);
        check("t6_rdy", saw_ready, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, v, ab, dir;
            int op, steps;
            logic [N-1:0] data;
            r     = ($urandom_range(0, 299) == 0);
            v     = ($urandom_range(0, 2) != 0);
            op    = $urandom_range(0, 9);
            op    = (op < 2) ? 0 : (op < 5) ? 1 : (op < 9) ? 2 : 3;
            dir   = $urandom_range(0, 1);
            data  = ($urandom_range(0, 1) != 0) ?
                    pat_of($urandom_range(0, 2*N-1)) : N'($urandom);
            steps = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
            ab    = ($urandom_range(0, 24) == 0);
            cyc(r, v, op, dir, data, steps, ab);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
